// File: rtl/mont_mult_unit.sv
// mont_mult_unit: bit-serial radix-2 Montgomery multiplier, result = a*b*2^-WIDTH mod m
module mont_mult_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, SUB} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_r, b_r, m_r, diff;
  logic [WIDTH+1:0] s, sum;
  logic [CW-1:0] i;
  logic q, last;
  assign busy = state != IDLE;
  assign last = i == CW'(WIDTH - 1);
  assign q = s[0] ^ (a_r[i] & b_r[0]);
  assign sum = s + (a_r[i] ? {2'b00, b_r} : '0) + (q ? {2'b00, m_r} : '0);
  assign diff = s[WIDTH-1:0] - m_r;
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state: start is only honoured while idle
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (start ? CALC : IDLE) : state == CALC ? (last ? SUB : CALC) : IDLE;
  end
  // operand latch, per-bit accumulate/halve, final conditional subtract
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      m_r <= '0;
      s <= '0;
      i <= '0;
      done <= 1'b0;
      result <= '0;
    end else begin
      done <= state == SUB;
      if (state == IDLE && start) begin
        a_r <= a;
        b_r <= b;
        m_r <= m;
        s <= '0;
        i <= '0;
      end
      if (state == CALC) begin
        s <= sum >> 1;
        i <= i + CW'(1);
      end
      if (state == SUB)
        result <= s >= {2'b00, m_r} ? diff : s[WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_mont_mult_unit.sv
// tb_mont_mult_unit: directed and random checks of the Montgomery multiplier
module tb_mont_mult_unit;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, busy, done;
  logic [7:0] a = '0, b = '0, m = '0, result;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mont_mult_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .m(m),
    .busy(busy), .done(done), .result(result)
  );
  task automatic check(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic int ref_mont(input int x, input int y, input int md);
    int inv = 0;
    for (int k = 1; k < md; k++)
      if ((256 * k) % md == 1) inv = k;
    return int'((longint'(x) * y * inv) % md);
  endfunction
  // mode bit0: extra start pulses at cycles 3 and 5; bit1: scramble inputs from cycle 1
  task automatic run(input string tag, input int x, input int y, input int md, input int exp, input int mode, input bit timing);
    a = 8'(x);
    b = 8'(y);
    m = 8'(md);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (mode[1]) begin
        a = 8'($urandom);
        b = 8'($urandom);
        m = 8'($urandom);
      end
      start = mode[0] && (c == 3 || c == 5);
      if (timing) begin
        check({tag, " busy"}, int'(busy), 1);
        check({tag, " no early done"}, int'(done), 0);
      end
      step();
    end
    start = 1'b0;
    check({tag, " done"}, int'(done), 1);
    check({tag, " busy at done"}, int'(busy), 0);
    check({tag, " result"}, int'(result), exp);
  endtask
  initial begin
    int x, y, md;
    step();
    step();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    rst = 1'b0;
    step();
    run("5*7 m13", 5, 7, 13, 1, 0, 1'b1);
    step();
    check("done pulse drops", int'(done), 0);
    check("result held", int'(result), 1);
    run("exit 1*9", 1, 9, 13, 1, 0, 1'b1);
    run("zero 0*9", 0, 9, 13, 0, 0, 1'b1);
    run("max 254*254 m255", 254, 254, 255, 1, 0, 1'b1);
    run("sub 12*12 m13", 12, 12, 13, 3, 1, 1'b1);
    step();
    check("single done after ignored starts", int'(done), 0);
    run("b2b first", 5, 7, 13, 1, 0, 1'b1);
    run("b2b second", 12, 12, 13, 3, 0, 1'b1);
    step();
    run("scrambled inputs", 200, 100, 211, ref_mont(200, 100, 211), 2, 1'b1);
    step();
    a = 8'd12; b = 8'd12; m = 8'd13;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort result", int'(result), 0);
    begin
      int seen = 0;
      for (int c = 0; c < 14; c++) begin
        seen += int'(done) + int'(busy);
        step();
      end
      check("no done after abort", seen, 0);
    end
    for (int n = 0; n < 1000; n++) begin
      md = 3 + 2 * int'($urandom_range(0, 126));
      x = int'($urandom_range(0, md - 1));
      y = int'($urandom_range(0, md - 1));
      run("random", x, y, md, ref_mont(x, y, md), 0, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
